// File: rtl/prng_word_serializer.sv
// Buffers IN_W-bit PRNG words in a small FIFO and serializes them into OUT_W-bit beats,
// most-significant slice first. Optional repetition health test: PRNG_SERIALIZER_HEALTH_EN.
module prng_word_serializer #(
  parameter int unsigned IN_W      = 128,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned REP_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            drop_cnt,
  output logic                   health_fail
);
  localparam int unsigned BEATS  = IN_W / OUT_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // The head word is loaded on the IDLE->SHIFT edge, so no separate load cycle exists.
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t            state;
  logic [IN_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [IN_W-1:0]   word_q;
  logic [BIDX_W-1:0] bidx;
  logic              ready_q;
  logic [LVL_W-1:0]  level_next;
  logic              empty, last, accept, push, pop, trip, fail_next;

  // in_ready is held low while reset is asserted; otherwise it is a pure register.
  assign in_ready = ready_q & rst;
  assign out_data = word_q[IN_W-1 -: OUT_W];
  assign empty    = (fifo_level == '0);
  assign last     = (bidx == BIDX_W'(BEATS - 1));
  assign accept   = in_valid && in_ready;
  assign push     = accept && !trip;
  assign pop      = !health_fail && !empty &&
                    ((state == S_IDLE) || (out_ready && last));
  assign fail_next = health_fail | trip;

  always_comb begin
    level_next = fifo_level;
    if (push && !pop)      level_next = fifo_level + LVL_W'(1);
    else if (pop && !push) level_next = fifo_level - LVL_W'(1);
  end

`ifdef PRNG_SERIALIZER_HEALTH_EN
  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

  logic [IN_W-1:0]  prev_word;
  logic [REP_W-1:0] rep_cnt, rep_next;

  // Run length of identical accepted words.
  always_comb begin
    rep_next = rep_cnt;
    if (accept) begin
      if ((rep_cnt != '0) && (in_data == prev_word)) rep_next = rep_cnt + REP_W'(1);
      else                                           rep_next = REP_W'(1);
    end
  end

  assign trip = accept && (rep_next == REP_W'(REP_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_word   <= '0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else begin
      if (accept) prev_word <= in_data;
      rep_cnt <= rep_next;
      if (trip) health_fail <= 1'b1;
    end
  end
`else
  assign trip        = 1'b0;
  assign health_fail = 1'b0;
`endif

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      word_q     <= '0;
      bidx       <= '0;
      out_valid  <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      ready_q    <= 1'b1;
      drop_cnt   <= '0;
    end else begin
      fifo_level <= level_next;
      ready_q    <= (level_next != LVL_W'(DEPTH)) && !fail_next;
      if (in_valid && !in_ready && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (health_fail) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (pop) begin
              word_q    <= mem[rd_ptr];
              bidx      <= '0;
              state     <= S_SHIFT;
              out_valid <= 1'b1;
            end
          end
          S_SHIFT: begin
            if (out_ready) begin
              if (!last) begin
                word_q <= word_q << OUT_W;
                bidx   <= bidx + BIDX_W'(1);
              end else if (pop) begin
                word_q <= mem[rd_ptr];
                bidx   <= '0;
              end else begin
                word_q    <= '0;
                bidx      <= '0;
                state     <= S_IDLE;
                out_valid <= 1'b0;
              end
            end
          end
          default: begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
